// File: rtl/switchbank_fifo_poll.sv
// switchbank_fifo_poll: polled switch-bank peripheral. A debounced press of the
// active-low enter key captures the synchronised switch word into a DEPTH-entry
// FIFO. The CPU reads the FIFO head (a0=0) or a status word (a0=1). It uses ack
// to pop an entry or to clear the sticky overflow flag.
module switchbank_fifo_poll #(
    parameter int DATA_W          = 16,
    parameter int DEPTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_switches,
    input  logic              i_enter_key,
    input  logic              i_a0,
    input  logic              i_ack,
    output logic [15:0]       o_data_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   FILL_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FILL_FULL = (PTR_W + 1)'(DEPTH);

    // Status word layout: count in the upper byte, flags in the low bits.
    function automatic logic [15:0] build_status(input logic [PTR_W:0] fill,
                                                 input logic ovf,
                                                 input logic full,
                                                 input logic not_empty);
        build_status = {8'(fill), 5'b00000, ovf, full, not_empty};
    endfunction

    logic [SYNC_STAGES-1:0] r_key_sync;
    logic [DATA_W-1:0]      r_sw_sync [SYNC_STAGES];
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_W-1:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W:0]         r_count;
    logic                   r_ovf;

    logic                   w_ks;
    logic [DATA_W-1:0]      w_sw;
    logic [1:0]             w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_push;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_ovf_set;
    logic                   w_ovf_clr;

    assign w_ks = r_key_sync[SYNC_STAGES-1];
    assign w_sw = r_sw_sync[SYNC_STAGES-1];

    // Synchronise the asynchronous key (idle high) and switch word into clk.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_key_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sw_sync[i] <= '0;
            end
        end else begin
            r_key_sync   <= {r_key_sync[SYNC_STAGES-2:0], i_enter_key};
            r_sw_sync[0] <= i_switches;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sw_sync[i] <= r_sw_sync[i-1];
            end
        end
    end

    // Debounce next-state logic; push fires once, on the cycle a press is accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                if (!w_ks) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_RELEASED;
                end
            end
            ST_PRESS_WAIT: begin
                if (w_ks) begin
                    w_state_nxt = ST_RELEASED;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = ST_PRESSED;
                    w_push      = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (w_ks) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_PRESSED;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!w_ks) begin
                    w_state_nxt = ST_PRESSED;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = ST_RELEASED;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_RELEASED;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Debounce state and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RELEASED;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FIFO control: a pop on a full FIFO frees the slot for a coincident push;
    // a pop on an empty FIFO is ignored, so a coincident push still lands.
    always_comb begin
        w_empty   = (r_count == FILL_ZERO);
        w_full    = (r_count == FILL_FULL);
        w_pop     = i_ack & ~i_a0 & ~w_empty;
        w_wr      = w_push & (~w_full | w_pop);
        w_ovf_set = w_push & w_full & ~w_pop;
        w_ovf_clr = i_ack & i_a0;
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_sw;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // FIFO pointers, fill count and sticky overflow (set beats clear).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= PTR_ZERO;
            r_wr_ptr <= PTR_ZERO;
            r_count  <= FILL_ZERO;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + FILL_ONE;
            end else if (w_pop && !w_wr) begin
                r_count <= r_count - FILL_ONE;
            end else begin
                r_count <= r_count;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    // Read mux: status word, or zero-extended FIFO head (zero when empty).
    always_comb begin
        if (i_a0) begin
            o_data_out = build_status(r_count, r_ovf, w_full, ~w_empty);
        end else if (w_empty) begin
            o_data_out = 16'h0000;
        end else begin
            o_data_out = 16'(r_mem[r_rd_ptr]);
        end
    end

endmodule

// File: doc/switchbank_fifo_poll.md
# switchbank_fifo_poll

Parametrised successor to the single-entry polled switch bank. It debounces the enter key and captures the switch word on each accepted press. Captured words go into a DEPTH-entry FIFO, so the CPU can poll several entries in order without losing presses. It sits on the CPU I/O bus as a polled peripheral with a 1-bit register select (a0) and a read-acknowledge strobe (ack).

## Interface
- DATA_W, 16: switch word width, 1..16; zero-extended to 16 on data_out.
- DEPTH, 4: FIFO entries, power of 2, 2..128.
- SYNC_STAGES, 2: synchroniser flops on enter_key and switches, ≥2.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a press or a release, ≥1.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- switches  in  DATA_W  user switch bank, asynchronous.
- enter_key  in  1  push button, active-low (idle 1), asynchronous, bouncy.
- a0  in  1  register select: 1 = status, 0 = data.
- ack  in  1  one-cycle CPU strobe, qualified by a0.
- data_out  out  16  combinational read data selected by a0.

## Operation
- Synchronisers:
  - enter_key and switches each pass through SYNC_STAGES flops.
  - The enter_key chain resets to 1; the switches chain resets to 0.
- Debounce FSM on synchronised key (ks), with counter cnt:
  - RELEASED: ks=0 → PRESS_WAIT, cnt←0.
  - PRESS_WAIT: ks=1 → RELEASED. Else if cnt==DEBOUNCE_CYCLES-1 → PRESSED and assert push for that cycle. Else cnt++.
  - PRESSED: ks=1 → RELEASE_WAIT, cnt←0.
  - RELEASE_WAIT: ks=0 → PRESSED (no push). Else if cnt==DEBOUNCE_CYCLES-1 → RELEASED. Else cnt++.
  - Exactly one push per accepted press. Holding the key produces no repeats.
- FIFO: circular buffer with rd_ptr, wr_ptr and count (0..DEPTH).
  - push writes the synchronised switches at wr_ptr.
  - pop = ack & ~a0 & (count≠0). It advances rd_ptr.
  - Pointers wrap modulo DEPTH.
- Push while full with no simultaneous pop: the word is dropped and the sticky ovf flag is set. The FIFO is unchanged.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - At full, this is not an overflow.
  - At empty, pop is ignored and push is accepted.
- Pop with count=0: no effect.
- ack & a0: clears ovf. If an overflow occurs in the same cycle, set wins.
- data_out, combinational:
  - a0=0: zero-extended FIFO head if count≠0, else 16'h0000.
  - a0=1: status word.
    - bit0 = not empty.
    - bit1 = full.
    - bit2 = ovf.
    - bits[15:8] = count.
    - All other bits 0.

## Timing
- Reset (rst=1 at an edge):
  - FSM → RELEASED, cnt=0.
  - Pointers=0, count=0, ovf=0.
  - Synchronisers at their reset values.
  - Result: data_out=16'h0000 for both a0 values.
  - FIFO contents need not be cleared.
- Reset mid-press or mid-debounce aborts without a push. A key still held after reset must first pass through PRESS_WAIT to be accepted.
- Press latency: enter_key first sampled low at edge N and held low. Then:
  - FSM enters PRESS_WAIT at edge N+SYNC_STAGES.
  - Push happens at edge N+SYNC_STAGES+DEBOUNCE_CYCLES.
  - Status count and data head are visible immediately after that edge.
- Captured word: switches as sampled SYNC_STAGES edges before the push edge. switches must be stable for SYNC_STAGES+DEBOUNCE_CYCLES cycles around the press.
- A low glitch on ks shorter than DEBOUNCE_CYCLES cycles produces no push.
- Pop: with ack&~a0 at edge M, the next entry appears on data_out after edge M. The CPU reads data_out in the cycle before or with ack.
- ack held for k cycles with a0=0 pops min(k, count) entries.

## Test plan
- Reset: assert rst 2 cycles with the key held low → data_out=0 for a0=0 and a0=1. After release, FSM is in RELEASED and count=0.
- Single press (DEPTH=4, DEBOUNCE_CYCLES=4): switches=16'h00A5, key low 20 cycles.
  - Status reads 16'h0101 exactly 6 edges after the first low sample.
  - a0=0 returns 16'h00A5.
  - ack with a0=0 → status 16'h0000.
- Bounce: key low 3 cycles, high 2, low 3, high → no push, count stays 0. A following clean press is pushed once.
- Fill and overflow: press with 1, 2, 3, 4, then 5.
  - After the 4th press, status 16'h0403.
  - After the 5th press, status 16'h0407.
  - Four pops return 1, 2, 3, 4; status then reads 16'h0004.
  - ack with a0=1 → status 16'h0000.
- Full push+pop: FIFO full with 1..4, push of 9 coincident with a pop.
  - count stays 4 and ovf stays 0.
  - Pops return 2, 3, 4, 9, including pointer wrap-around.
- Reset mid-operation: 2 entries queued and a key in PRESS_WAIT, assert rst → status 0. The held key gives no push until the release and press sequence completes.
